// File: rtl/render_pkg.sv
// Shared constants for the shape-renderer chain: beat widths, register IDs
// and default raster timing.
package render_pkg;

    localparam int COORD_W = 12;
    localparam int COLOR_W = 12;

    localparam logic [COORD_W-1:0] REG_XCOORD = 12'd0;
    localparam logic [COORD_W-1:0] REG_YCOORD = 12'd1;
    localparam logic [COORD_W-1:0] REG_WIDTH  = 12'd2;
    localparam logic [COORD_W-1:0] REG_HEIGHT = 12'd3;
    localparam logic [COORD_W-1:0] REG_COLOR  = 12'd4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;

    // Programming entry layout: {stage, reg, data}
    localparam int ENTRY_W = 2 * COORD_W + COLOR_W;

endpackage

// File: rtl/prog_fifo.sv
// Synchronous FIFO of register-programming entries; readiness is derived
// from the registered level only, so a full FIFO refuses even on a pop cycle.
module prog_fifo
    import render_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [AW:0]        level
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic               do_push;
    logic               do_pop;

    assign push_ready = (level != (AW+1)'(DEPTH));
    assign rd_valid   = (level != '0);
    assign rd_data    = mem[rptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && rd_valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/render_chain_source.sv
// Head of the renderer chain: raster-scans the frame, emitting pixel beats,
// and drains queued programming writes during vertical blanking.
module render_chain_source
    import render_pkg::*;
#(
    parameter int                 H_ACTIVE   = DEF_H_ACTIVE,
    parameter int                 H_TOTAL    = DEF_H_TOTAL,
    parameter int                 V_ACTIVE   = DEF_V_ACTIVE,
    parameter int                 V_TOTAL    = DEF_V_TOTAL,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000,
    parameter int                 FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [COORD_W-1:0]          wr_stage,
    input  logic [COORD_W-1:0]          wr_reg,
    input  logic [COLOR_W-1:0]          wr_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_start,
    output logic                        program_out,
    output logic [COORD_W-1:0]          x_out,
    output logic [COORD_W-1:0]          y_out,
    output logic [COLOR_W-1:0]          data_out
);

    if (H_TOTAL <= H_ACTIVE || H_TOTAL > 4096 ||
        V_TOTAL <= V_ACTIVE || V_TOTAL > 4096 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("render_chain_source: illegal parameters");
    end

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_BLANK = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic               blank;
    logic               fifo_valid;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign blank = (vcnt >= V_BLANK);
    assign pop   = blank && fifo_valid;

    prog_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (wr_valid),
        .push_ready (wr_ready),
        .push_data  ({wr_stage, wr_reg, wr_data}),
        .pop        (pop),
        .rd_valid   (fifo_valid),
        .rd_data    (head),
        .level      (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Programming beats steal idle blanking slots; pixel/idle beats carry the raster position.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            program_out <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            data_out    <= BG_COLOR;
        end else begin
            frame_start <= (hcnt == '0) && (vcnt == '0);
            program_out <= pop;
            if (pop) begin
                {x_out, y_out, data_out} <= head;
            end else begin
                x_out    <= hcnt;
                y_out    <= vcnt;
                data_out <= BG_COLOR;
            end
        end
    end

endmodule
